// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the parametrised memory-sequence game: state codes
// and indices into the configuration word.
package jogo_memoria_pkg;

  localparam logic [3:0] ST_INICIAL      = 4'h0;
  localparam logic [3:0] ST_PREPARACAO   = 4'h1;
  localparam logic [3:0] ST_MOSTRA_LED   = 4'h2;
  localparam logic [3:0] ST_MOSTRA_APAG  = 4'h3;
  localparam logic [3:0] ST_ESPERA       = 4'h4;
  localparam logic [3:0] ST_REGISTRA     = 4'h5;
  localparam logic [3:0] ST_COMPARA      = 4'h6;
  localparam logic [3:0] ST_PROXIMA      = 4'h7;
  localparam logic [3:0] ST_ADICIONA     = 4'h8;
  localparam logic [3:0] ST_REG_NOVA     = 4'h9;
  localparam logic [3:0] ST_GANHOU       = 4'hA;
  localparam logic [3:0] ST_PERDEU       = 4'hB;
  localparam logic [3:0] ST_TIMEOUT      = 4'hC;

  localparam int CFG_DEMO    = 0;
  localparam int CFG_TIMEOUT = 1;

endpackage

// File: rtl/ram_sequencia.sv
// Sequence storage: one synchronous write port, one asynchronous read port.
// Contents are not reset so a preloaded sequence survives a game restart.
module ram_sequencia #(
  parameter int PROF     = 16,
  parameter int N_BOTOES = 4,
  localparam int AW      = $clog2(PROF)
) (
  input  logic                i_clock,
  input  logic                i_we,
  input  logic [AW-1:0]       i_end_w,
  input  logic [N_BOTOES-1:0] i_dado_w,
  input  logic [AW-1:0]       i_end_r,
  output logic [N_BOTOES-1:0] o_dado_r
);

  logic [N_BOTOES-1:0] r_mem [PROF];

  // Synchronous write of the single muxed port
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_end_w] <= i_dado_w;
    end
  end

  assign o_dado_r = r_mem[i_end_r];

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-sequence game core: shows the stored sequence, checks the replay,
// appends one player move per round and reports win/lose/timeout and score.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BOTOES  = 4,
  parameter int PROF      = 16,
  parameter int LIM_DEMO  = 4,
  parameter int T_LED     = 500,
  parameter int T_APAGADO = 250,
  parameter int T_TIMEOUT = 3000,
  localparam int AW       = $clog2(PROF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [1:0]          configuracao,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                carga_we,
  input  logic [AW-1:0]       carga_end,
  input  logic [N_BOTOES-1:0] carga_dado,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic                pronto,
  output logic [AW:0]         rodada,
  output logic [3:0]          db_estado
);

  localparam int T_MAX = (T_LED > T_APAGADO) ?
                         ((T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT) :
                         ((T_APAGADO > T_TIMEOUT) ? T_APAGADO : T_TIMEOUT);
  localparam int TW = $clog2(T_MAX + 1);

  function automatic logic is_one_hot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

  logic [3:0]          r_estado;
  logic [3:0]          w_prox;
  logic [AW-1:0]       r_end;
  logic [AW-1:0]       r_rod;
  logic [AW:0]         r_rodada;
  logic [AW:0]         r_lim;
  logic                r_timeout_en;
  logic [TW-1:0]       r_timer;
  logic [N_BOTOES-1:0] r_jogada;
  logic [N_BOTOES-1:0] r_botoes_q;

  logic                w_press;
  logic                w_expirou;
  logic                w_acerto;
  logic                w_ultima;
  logic                w_repouso;
  logic                w_we;
  logic [AW-1:0]       w_end_w;
  logic [N_BOTOES-1:0] w_dado_w;
  logic [N_BOTOES-1:0] w_mem_dado;

  ram_sequencia #(.PROF(PROF), .N_BOTOES(N_BOTOES)) u_ram (
    .i_clock  (clock),
    .i_we     (w_we),
    .i_end_w  (w_end_w),
    .i_dado_w (w_dado_w),
    .i_end_r  (r_end),
    .o_dado_r (w_mem_dado)
  );

  // Only rising edges count, so a button held across a state change is ignored
  assign w_press   = |(botoes & ~r_botoes_q);
  assign w_expirou = r_timeout_en && (r_timer == TW'(T_TIMEOUT - 1));
  assign w_acerto  = is_one_hot(r_jogada) && (r_jogada == w_mem_dado);
  assign w_ultima  = (({1'b0, r_rod} + (AW+1)'(1)) == r_lim);
  assign w_repouso = (r_estado == ST_INICIAL) || (r_estado == ST_GANHOU) ||
                     (r_estado == ST_PERDEU)  || (r_estado == ST_TIMEOUT);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ST_INICIAL, ST_GANHOU, ST_PERDEU, ST_TIMEOUT: begin
        if (jogar) w_prox = ST_PREPARACAO;
        else       w_prox = r_estado;
      end
      ST_PREPARACAO: w_prox = ST_MOSTRA_LED;
      ST_MOSTRA_LED: begin
        if (r_timer == TW'(T_LED - 1)) w_prox = ST_MOSTRA_APAG;
        else                           w_prox = ST_MOSTRA_LED;
      end
      ST_MOSTRA_APAG: begin
        if (r_timer != TW'(T_APAGADO - 1)) w_prox = ST_MOSTRA_APAG;
        else if (r_end == r_rod)           w_prox = ST_ESPERA;
        else                               w_prox = ST_MOSTRA_LED;
      end
      ST_ESPERA: begin
        if (w_press)        w_prox = ST_REGISTRA;
        else if (w_expirou) w_prox = ST_TIMEOUT;
        else                w_prox = ST_ESPERA;
      end
      ST_REGISTRA: w_prox = ST_COMPARA;
      ST_COMPARA: begin
        if (!w_acerto)          w_prox = ST_PERDEU;
        else if (r_end != r_rod) w_prox = ST_ESPERA;
        else if (w_ultima)      w_prox = ST_GANHOU;
        else                    w_prox = ST_ADICIONA;
      end
      ST_ADICIONA: begin
        if (w_press)        w_prox = is_one_hot(botoes) ? ST_REG_NOVA : ST_PERDEU;
        else if (w_expirou) w_prox = ST_TIMEOUT;
        else                w_prox = ST_ADICIONA;
      end
      ST_REG_NOVA: w_prox = ST_MOSTRA_LED;
      ST_PROXIMA:  w_prox = ST_INICIAL;  // reserved code, never entered
      default:     w_prox = ST_INICIAL;
    endcase
  end

  // Datapath: timer, counters, config latch, captured move, button history
  always_ff @(posedge clock) begin
    if (reset) begin
      r_end        <= '0;
      r_rod        <= '0;
      r_rodada     <= '0;
      r_lim        <= '0;
      r_timeout_en <= 1'b0;
      r_timer      <= '0;
      r_jogada     <= '0;
      r_botoes_q   <= '0;
    end else begin
      r_botoes_q <= botoes;
      if (w_prox != r_estado)           r_timer <= '0;
      else if (r_timer != {TW{1'b1}})   r_timer <= r_timer + TW'(1);
      case (r_estado)
        ST_INICIAL, ST_GANHOU, ST_PERDEU, ST_TIMEOUT: begin
          if (jogar) begin
            r_timeout_en <= configuracao[CFG_TIMEOUT];
            r_lim <= configuracao[CFG_DEMO] ? (AW+1)'(LIM_DEMO) : (AW+1)'(PROF);
          end
        end
        ST_PREPARACAO: begin
          r_end    <= '0;
          r_rod    <= '0;
          r_rodada <= '0;
        end
        ST_MOSTRA_APAG: begin
          if (r_timer == TW'(T_APAGADO - 1)) begin
            r_end <= (r_end == r_rod) ? '0 : r_end + AW'(1);
          end
        end
        ST_ESPERA, ST_ADICIONA: begin
          if (w_press) r_jogada <= botoes;
        end
        ST_COMPARA: begin
          if (w_acerto) begin
            if (r_end != r_rod) r_end    <= r_end + AW'(1);
            else if (w_ultima)  r_rodada <= r_lim;
            else                r_rodada <= {1'b0, r_rod} + (AW+1)'(1);
          end
        end
        ST_REG_NOVA: begin
          r_rod <= r_rod + AW'(1);
          r_end <= '0;
        end
        default: ;
      endcase
    end
  end

  // RAM write port: appended move has priority, preload only while idle
  always_comb begin
    w_we     = 1'b0;
    w_end_w  = carga_end;
    w_dado_w = carga_dado;
    if (reset) begin
      w_we = 1'b0;
    end else if (r_estado == ST_REG_NOVA) begin
      w_we     = 1'b1;
      w_end_w  = r_rod + AW'(1);
      w_dado_w = r_jogada;
    end else if (carga_we && w_repouso) begin
      w_we = 1'b1;
    end else begin
      w_we = 1'b0;
    end
  end

  // Output decode
  always_comb begin
    leds = '0;
    case (r_estado)
      ST_MOSTRA_LED:          leds = w_mem_dado;
      ST_ESPERA, ST_ADICIONA: leds = botoes;
      default:                leds = '0;
    endcase
  end

  assign ganhou    = (r_estado == ST_GANHOU);
  assign perdeu    = (r_estado == ST_PERDEU) || (r_estado == ST_TIMEOUT);
  assign timeout   = (r_estado == ST_TIMEOUT);
  assign pronto    = w_repouso && (r_estado != ST_INICIAL);
  assign rodada    = r_rodada;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param: a scoreboard queue holds the
// moves each display phase must show; game outcomes are checked at the end.
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [1:0] configuracao;
  logic [3:0] botoes;
  logic       carga_we;
  logic [3:0] carga_end;
  logic [3:0] carga_dado;
  logic [3:0] leds;
  logic       ganhou, perdeu, timeout, pronto;
  logic [4:0] rodada;
  logic [3:0] db_estado;

  int n_err = 0;
  int n_chk = 0;
  logic [3:0] mem_m [16];
  logic [3:0] exp_q [$];
  logic [3:0] estado_ant = 4'h0;
  logic [3:0] adds [3];

  jogo_memoria_param #(
    .N_BOTOES(4), .PROF(16), .LIM_DEMO(4),
    .T_LED(4), .T_APAGADO(2), .T_TIMEOUT(20)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
    .botoes(botoes), .carga_we(carga_we), .carga_end(carga_end),
    .carga_dado(carga_dado), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .pronto(pronto), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every entry into the led phase pops one expected move
  always @(negedge clock) begin
    if (db_estado == 4'h2 && estado_ant != 4'h2) begin
      if (exp_q.size() == 0) check_eq("show_unexpected", 32'(exp_q.size()), 32'd1);
      else                   check_eq("show_led", leds, exp_q.pop_front());
    end
    estado_ant <= db_estado;
  end

  task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
    int n = 0;
    while (db_estado !== code && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, db_estado, code);
  endtask

  task automatic press(input logic [3:0] v, input string tag);
    int n = 0;
    while (db_estado !== 4'h4 && db_estado !== 4'h8 && n < 200) begin
      @(negedge clock);
      n++;
    end
    botoes = v;
    #1 check_eq({tag, "_echo"}, leds, v);
    @(negedge clock);
    botoes = 4'h0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [3:0] v);
    carga_we = 1'b1; carga_end = a; carga_dado = v;
    mem_m[a] = v;
    @(negedge clock);
    carga_we = 1'b0;
  endtask

  task automatic push_show(input int r);
    for (int i = 0; i <= r; i++) exp_q.push_back(mem_m[i]);
  endtask

  task automatic start_game(input logic [1:0] cfg);
    configuracao = cfg;
    jogar = 1'b1;
    exp_q.push_back(mem_m[0]);
    @(negedge clock);
    jogar = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; jogar = 1'b0; configuracao = 2'b00; botoes = 4'h0;
    carga_we = 1'b0; carga_end = 4'h0; carga_dado = 4'h0;
    adds[0] = 4'b0010; adds[1] = 4'b0100; adds[2] = 4'b1000;
    repeat (3) @(negedge clock);
    check_eq("rst_estado", db_estado, 4'h0);
    check_eq("rst_leds", leds, 4'h0);
    check_eq("rst_rodada", rodada, 5'd0);
    check_eq("rst_flags", {ganhou, perdeu, timeout, pronto}, 4'b0000);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 16; i++) preload(4'(i), 4'(1 << (i % 4)));

    // Demo game won after four rounds
    start_game(2'b01);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i <= r; i++) press(mem_m[i], "t1_rep");
      if (r < 3) begin
        wait_state(4'h8, 5, "t1_adiciona");
        press(adds[r], "t1_add");
        mem_m[r+1] = adds[r];
        push_show(r + 1);
      end
    end
    wait_state(4'hA, 10, "t1_final_ganhou");
    check_eq("t1_ganhou_pronto", {ganhou, pronto, perdeu}, 3'b110);
    check_eq("t1_rodada", rodada, 5'd4);
    check_eq("t1_leds_off", leds, 4'h0);
    check_eq("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous press during replay loses
    start_game(2'b11);
    press(mem_m[0], "t2_rep");
    wait_state(4'h8, 5, "t2_adiciona");
    press(4'b0010, "t2_add");
    mem_m[1] = 4'b0010;
    push_show(1);
    press(4'b1111, "t2_multi");
    wait_state(4'hB, 10, "t2_final_perdeu");
    check_eq("t2_flags", {perdeu, timeout, ganhou, pronto}, 4'b1001);
    check_eq("t2_rodada", rodada, 5'd1);

    // Timeout exactly T_TIMEOUT cycles after entering espera
    start_game(2'b11);
    wait_state(4'h4, 100, "t3_espera");
    repeat (19) @(negedge clock);
    check_eq("t3_last_cycle", db_estado, 4'h4);
    @(negedge clock);
    check_eq("t3_estado", db_estado, 4'hC);
    check_eq("t3_flags", {timeout, perdeu, pronto, ganhou}, 4'b1110);

    // Timeout disabled: waits indefinitely; then reset mid display
    start_game(2'b01);
    wait_state(4'h4, 100, "t4_espera");
    repeat (200) @(negedge clock);
    check_eq("t4_still_espera", db_estado, 4'h4);
    check_eq("t4_no_timeout", timeout, 1'b0);
    press(mem_m[0], "t4_rep");
    wait_state(4'h8, 5, "t4_adiciona");
    press(4'b0100, "t4_add");
    mem_m[1] = 4'b0100;
    push_show(1);
    wait_state(4'h2, 10, "t6_mostra");
    @(negedge clock);
    check_eq("t6_rodada_pre", rodada, 5'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    check_eq("t6_rst_estado", db_estado, 4'h0);
    check_eq("t6_rst_leds", leds, 4'h0);
    check_eq("t6_rst_rodada", rodada, 5'd0);
    start_game(2'b01);
    press(mem_m[0], "t6_rep");
    wait_state(4'h8, 5, "t6_restart_ok");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();

    // Preload honoured while idle, ignored during play
    preload(4'h0, 4'b1000);
    start_game(2'b01);
    wait_state(4'h4, 100, "t5_espera");
    carga_we = 1'b1; carga_end = 4'h0; carga_dado = 4'b0100;
    @(negedge clock);
    carga_we = 1'b0;
    press(4'b1000, "t5_rep");
    wait_state(4'h8, 5, "t5_ram_kept");
    press(4'b0011, "t5_multi_add");
    wait_state(4'hB, 5, "t5_multi_lose");
    check_eq("t5_rodada", rodada, 5'd1);
    check_eq("t5_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
